tspi_rx: RTL and testbench
==========================

Name: tspi_rx

Overview:
- SPI mode-0 receiver (peripheral side): the capture end of the link driven by the team's SPI transmitter.
- Oversamples external CSN/SCLK/MOSI on the system clock, detects edges, and shifts MOSI in MSB-first.
- Emits one-cycle word strobes plus frame-end/error flags to downstream logic.
- Includes a SCLK inactivity watchdog so a stalled master cannot hang the receiver.

Parameters:
- SPI0_0, 8, word width in bits (≥2).
- SPI0_2, 32, width of the timeout threshold/counter.
- SYNC_STG, 2, input synchronizer depth (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- CSN  in  1  async chip select, active low.
- SCLK  in  1  async serial clock, idle low.
- MOSI  in  1  async serial data.
- del_to  in  SPI0_2  SCLK-inactivity timeout in clk cycles; 0 disables.
- rx_idle  out  1  high when no frame is in progress.
- rx_valid  out  1  one-cycle strobe; rx_data holds a new word.
- rx_data  out  SPI0_0  last completed word; held until the next word.
- rx_frm_end  out  1  one-cycle strobe on frame close (CSN rise or timeout).
- rx_err  out  1  one-cycle strobe: partial word discarded, or timeout.

Behaviour:
- Reset: sync flops CSN=1/SCLK=0/MOSI=0; rx_idle=1; rx_valid=0; rx_data=0; rx_frm_end=0; rx_err=0; bit count 0; armed=0; state IDLE. Reset mid-frame aborts with no strobes.
- Synchronization and edges:
  - All three inputs pass through a SYNC_STG-deep chain, plus one history flop for edge detection.
  - SCLK rise = history 0, synced 1. CSN fall/rise likewise.
- Arming: after reset, armed sets only once synced CSN is seen high for ≥1 cycle. A CSN fall while armed=0 is ignored, so a frame cut by reset is never picked up mid-way.
- FSM IDLE -> ACTIVE:
  - IDLE to ACTIVE on CSN fall with armed=1; rx_idle goes 0 on that same cycle.
  - Bit count and timeout counter clear on entry.
  - SCLK edges in IDLE are ignored.
- ACTIVE, each SCLK rise:
  - Shift reg = {shift[SPI0_0-2:0], synced MOSI}; MOSI is sampled at the same sync stage as SCLK.
  - Bit count increments.
  - On reaching SPI0_0: rx_data <= completed word, rx_valid=1 for one cycle, count wraps to 0, reception continues without gaps.
- Latency: raw SCLK final-bit rise first captured at clk edge k -> rx_valid high at edge k+SYNC_STG+1.
- ACTIVE, CSN rise:
  - rx_frm_end pulses.
  - If bit count≠0, rx_err pulses and the partial word is dropped; rx_data is unchanged.
  - Next state IDLE; rx_idle=1 from the next cycle.
- Simultaneous CSN rise and final SCLK rise: the bit is accepted; rx_valid and rx_frm_end pulse on the same cycle; no rx_err.
- ACTIVE, timeout:
  - Counter clears on each SCLK rise and increments otherwise, saturating.
  - When del_to≠0 and counter==del_to: rx_err and rx_frm_end pulse, bit count clears, state WAIT_CSH.
- WAIT_CSH: ignores SCLK; moves to IDLE on synced CSN high.
- Width rules:
  - Timeout counter is SPI0_2 bits, saturating at all-ones (no wrap).
  - Bit count is clog2(SPI0_0+1) bits.

Optional Feature:
- Macro TSPI_RX_FILT_EN.
- Defined: synced SCLK and CSN each pass a 3-sample agreement filter. The output changes only when 3 consecutive samples agree, which rejects glitches shorter than 3 clk cycles and adds 2 cycles to all latencies (rx_valid at k+SYNC_STG+3). MOSI is delayed 2 cycles to stay aligned.
- Undefined: no filter; latencies exactly as above.

Test Plan:
- Reset released with CSN high, then one frame 0xA5 (SCLK = clk/8) -> single rx_valid with rx_data=0xA5 at k+3; rx_frm_end on CSN rise; rx_err never asserts.
- Back-to-back frame 0x3C,0xFF,0x01 within one CSN low -> three rx_valid pulses with the data in order; one rx_frm_end; rx_idle=0 throughout.
- CSN rises after 5 bits -> rx_err and rx_frm_end pulse together; rx_data keeps its previous value; rx_valid stays 0.
- del_to=20, SCLK stops after 3 bits with CSN held low -> rx_err and rx_frm_end 20 cycles after the last SCLK rise; later SCLK edges ignored until CSN high; the next frame 0x5A is received correctly.
- rst asserted mid-frame with CSN low, then released -> no strobes; remaining bits ignored until CSN high then low; next frame 0x81 received.
- With TSPI_RX_FILT_EN defined, 1-cycle SCLK glitches injected during frame 0x96 -> rx_data=0x96 at k+SYNC_STG+3; without the macro the same stimulus yields extra bits.

Source files
------------

// File: rtl/tspi_rx.sv
// tspi_rx: SPI mode-0 peripheral receiver (MSB-first) with input sync, edge detect and SCLK watchdog.
// Build option: define TSPI_RX_FILT_EN to add a 3-sample agreement glitch filter on SCLK/CSN.
//
// state      | meaning
// S_IDLE     | no frame; waiting for an armed CSN fall
// S_ACTIVE   | CSN low, shifting MOSI on each SCLK rise
// S_WAIT_CSH | frame killed by the watchdog; waiting for CSN high
module tspi_rx #(
    parameter int SPI0_0   = 8,
    parameter int SPI0_2   = 32,
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CSN,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic [SPI0_2-1:0] del_to,
    output logic              rx_idle,
    output logic              rx_valid,
    output logic [SPI0_0-1:0] rx_data,
    output logic              rx_frm_end,
    output logic              rx_err
);

    localparam int CW = $clog2(SPI0_0 + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SPI0_0 - 1);
`ifdef TSPI_RX_FILT_EN
    localparam int FLAT = 2;
`else
    localparam int FLAT = 0;
`endif
    localparam int LIVE = SYNC_STG + FLAT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_WAIT_CSH
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STG-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q;
    logic                csn_s, sclk_s, mosi_s;
    logic                csn_f, sclk_f, mosi_f;
    logic                csn_h_q, sclk_h_q;
    logic                sclk_rise_q, csn_fall_q, csn_rise_q, mosi_q;
    logic [LIVE-1:0]     live_q;
    logic                armed_q, armed_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SPI0_0-2:0]   shift_q, shift_d;
    logic [SPI0_0-1:0]   next_word;
    logic [SPI0_2-1:0]   to_cnt_q, to_cnt_d;
    logic [SPI0_0-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                frm_end_q, frm_end_d;
    logic                err_q, err_d;

    assign csn_s  = csn_sync_q[SYNC_STG-1];
    assign sclk_s = sclk_sync_q[SYNC_STG-1];
    assign mosi_s = mosi_sync_q[SYNC_STG-1];

`ifdef TSPI_RX_FILT_EN
    logic [1:0] csn_fh_q, sclk_fh_q, mosi_dly_q;
    logic       csn_fo_q, sclk_fo_q;

    // Output follows the input only once it and the two previous samples agree.
    assign csn_f  = (csn_s == csn_fh_q[0] && csn_s == csn_fh_q[1]) ? csn_s : csn_fo_q;
    assign sclk_f = (sclk_s == sclk_fh_q[0] && sclk_s == sclk_fh_q[1]) ? sclk_s : sclk_fo_q;
    assign mosi_f = mosi_dly_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            csn_fh_q   <= 2'b11;
            sclk_fh_q  <= 2'b00;
            csn_fo_q   <= 1'b1;
            sclk_fo_q  <= 1'b0;
            mosi_dly_q <= 2'b00;
        end else begin
            csn_fh_q   <= {csn_fh_q[0], csn_s};
            sclk_fh_q  <= {sclk_fh_q[0], sclk_s};
            csn_fo_q   <= csn_f;
            sclk_fo_q  <= sclk_f;
            mosi_dly_q <= {mosi_dly_q[0], mosi_s};
        end
    end
`else
    assign csn_f  = csn_s;
    assign sclk_f = sclk_s;
    assign mosi_f = mosi_s;
`endif

    assign next_word = {shift_q, mosi_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            csn_sync_q  <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_h_q     <= 1'b1;
            sclk_h_q    <= 1'b0;
            sclk_rise_q <= 1'b0;
            csn_fall_q  <= 1'b0;
            csn_rise_q  <= 1'b0;
            mosi_q      <= 1'b0;
            live_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frm_end_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            csn_sync_q  <= {csn_sync_q[SYNC_STG-2:0], CSN};
            sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], MOSI};
            csn_h_q     <= csn_f;
            sclk_h_q    <= sclk_f;
            sclk_rise_q <= sclk_f & ~sclk_h_q;
            csn_fall_q  <= ~csn_f & csn_h_q;
            csn_rise_q  <= csn_f & ~csn_h_q;
            mosi_q      <= mosi_f;
            // Marks when the pipeline holds real samples rather than reset values.
            live_q      <= {live_q[LIVE-2:0], 1'b1};
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frm_end_q   <= frm_end_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        frm_end_d = 1'b0;
        err_d     = 1'b0;
        armed_d   = armed_q | (csn_f & live_q[LIVE-1]);

        case (state_q)
            S_IDLE: begin
                if (csn_fall_q && armed_q) begin
                    state_d   = S_ACTIVE;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                end
            end
            S_ACTIVE: begin
                if (sclk_rise_q) begin
                    shift_d  = next_word[SPI0_0-2:0];
                    to_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d    = next_word;
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + SPI0_2'(1);
                end

                // A final bit landing with CSN rise has already wrapped the count to 0.
                if (csn_rise_q) begin
                    frm_end_d = 1'b1;
                    err_d     = (bit_cnt_d != '0);
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end else if (!sclk_rise_q && del_to != '0 && to_cnt_q == del_to) begin
                    frm_end_d = 1'b1;
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_WAIT_CSH;
                end
            end
            S_WAIT_CSH: begin
                if (csn_f) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_idle    = (state_q != S_ACTIVE);
    assign rx_valid   = valid_q;
    assign rx_data    = data_q;
    assign rx_frm_end = frm_end_q;
    assign rx_err     = err_q;

endmodule

// File: tb/tb_tspi_rx.sv
// tb_tspi_rx: randomized self-checking bench for tspi_rx; expected words come from a bit-stream model.
// Builds with or without TSPI_RX_FILT_EN; the glitch scenario expectation follows the build.
`timescale 1ns/1ps
module tb_tspi_rx;
    localparam int W    = 8;
    localparam int TW   = 32;
    localparam int SYNC = 2;
`ifdef TSPI_RX_FILT_EN
    localparam int FLAT = 2;
`else
    localparam int FLAT = 0;
`endif
    // Raw SCLK rise captured at edge k -> word strobe at edge k+LAT.
    localparam int LAT  = SYNC + 1 + FLAT;
    localparam int HALF = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          CSN = 1'b1;
    logic          SCLK = 1'b0;
    logic          MOSI = 1'b0;
    logic [TW-1:0] del_to = '0;
    logic          rx_idle, rx_valid, rx_frm_end, rx_err;
    logic [W-1:0]  rx_data;

    tspi_rx #(.SPI0_0(W), .SPI0_2(TW), .SYNC_STG(SYNC)) dut (
        .clk(clk), .rst(rst), .CSN(CSN), .SCLK(SCLK), .MOSI(MOSI), .del_to(del_to),
        .rx_idle(rx_idle), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_frm_end(rx_frm_end), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled 1 ns after each rising edge.
    logic [W-1:0] got [0:1023];
    int n_valid = 0, n_frm = 0, n_err = 0, idle_bad = 0;
    int valid_cyc = 0, frm_cyc = 0, err_cyc = 0;
    bit watch = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            got[n_valid] = rx_data;
            n_valid++;
            valid_cyc = cyc;
        end
        if (rx_frm_end === 1'b1) begin
            n_frm++;
            frm_cyc = cyc;
        end
        if (rx_err === 1'b1) begin
            n_err++;
            err_cyc = cyc;
        end
        if (watch && rx_idle !== 1'b0) idle_bad++;
    end

    int tests_run = 0, tests_failed = 0;
    int last_rise = 0;
    logic [W-1:0] exp_data = '0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit: data set with SCLK low, sampled by the rise. Optional 1-cycle glitch in the low phase.
    task automatic sclk_bit(input logic b, input bit glitch);
        MOSI = b;
        SCLK = 1'b0;
        if (glitch) begin
            tick(3);
            SCLK = 1'b1;
            tick(1);
            SCLK = 1'b0;
            tick(3);
        end else begin
            tick(HALF);
        end
        SCLK = 1'b1;
        last_rise = cyc + 1;
        tick(HALF);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit glitch);
        for (int i = n - 1; i >= 0; i--) sclk_bit(v[i], glitch);
    endtask

    task automatic end_frame();
        SCLK = 1'b0;
        tick(HALF);
        CSN = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        CSN = 1'b1;
        tick(4);
        tests_run++; if (rx_idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %b want 1", rx_idle); end
        tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", rx_data); end
        tests_run++; if (rx_frm_end !== 1'b0) begin tests_failed++; $display("FAIL reset_frm_end: got %b want 0", rx_frm_end); end
        tests_run++; if (rx_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", rx_err); end
        rst = 1'b0;
        tick(10);
        tests_run++; if (rx_idle !== 1'b1) begin tests_failed++; $display("FAIL post_reset_idle: got %b want 1", rx_idle); end
    endtask

    task automatic test_single_frame();
        int v0, f0, e0, k;
        v0 = n_valid; f0 = n_frm; e0 = n_err;
        CSN = 1'b0;
        tick(HALF);
        send_bits(32'hA5, W, 1'b0);
        k = last_rise;
        end_frame();
        exp_data = 8'hA5;
        tests_run++; if (n_valid - v0 != 1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", n_valid - v0); end
        tests_run++; if (got[v0] !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h want a5", got[v0]); end
        tests_run++; if (valid_cyc != k + LAT) begin tests_failed++; $display("FAIL single_latency: got cycle %0d want %0d", valid_cyc, k + LAT); end
        tests_run++; if (n_frm - f0 != 1) begin tests_failed++; $display("FAIL single_frm_end: got %0d want 1", n_frm - f0); end
        tests_run++; if (n_err != e0) begin tests_failed++; $display("FAIL single_err: got %0d want 0", n_err - e0); end
        tests_run++; if (rx_data !== 8'hA5) begin tests_failed++; $display("FAIL single_hold: got %h want a5", rx_data); end
        tests_run++; if (rx_idle !== 1'b1) begin tests_failed++; $display("FAIL single_idle_after: got %b want 1", rx_idle); end
    endtask

    task automatic test_back_to_back();
        int v0, f0, e0, ib0;
        logic [W-1:0] w [3];
        w[0] = 8'h3C; w[1] = 8'hFF; w[2] = 8'h01;
        v0 = n_valid; f0 = n_frm; e0 = n_err; ib0 = idle_bad;
        CSN = 1'b0;
        tick(6);
        watch = 1'b1;
        for (int i = 0; i < 3; i++) send_bits({24'h0, w[i]}, W, 1'b0);
        SCLK = 1'b0;
        tick(HALF);
        watch = 1'b0;
        CSN = 1'b1;
        tick(12);
        exp_data = w[2];
        tests_run++; if (n_valid - v0 != 3) begin tests_failed++; $display("FAIL b2b_count: got %0d want 3", n_valid - v0); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (got[v0 + i] !== w[i]) begin tests_failed++; $display("FAIL b2b_data%0d: got %h want %h", i, got[v0 + i], w[i]); end
        end
        tests_run++; if (n_frm - f0 != 1) begin tests_failed++; $display("FAIL b2b_frm_end: got %0d want 1", n_frm - f0); end
        tests_run++; if (n_err != e0) begin tests_failed++; $display("FAIL b2b_err: got %0d want 0", n_err - e0); end
        tests_run++; if (idle_bad != ib0) begin tests_failed++; $display("FAIL b2b_idle_low: idle high for %0d cycles want 0", idle_bad - ib0); end
    endtask

    task automatic test_partial(input int nb);
        int v0, f0, e0;
        v0 = n_valid; f0 = n_frm; e0 = n_err;
        CSN = 1'b0;
        tick(HALF);
        send_bits($urandom, nb, 1'b0);
        end_frame();
        tests_run++; if (n_err - e0 != 1) begin tests_failed++; $display("FAIL partial%0d_err: got %0d want 1", nb, n_err - e0); end
        tests_run++; if (n_frm - f0 != 1) begin tests_failed++; $display("FAIL partial%0d_frm_end: got %0d want 1", nb, n_frm - f0); end
        tests_run++; if (err_cyc != frm_cyc) begin tests_failed++; $display("FAIL partial%0d_same_cycle: err at %0d want %0d", nb, err_cyc, frm_cyc); end
        tests_run++; if (n_valid != v0) begin tests_failed++; $display("FAIL partial%0d_valid: got %0d want 0", nb, n_valid - v0); end
        tests_run++; if (rx_data !== exp_data) begin tests_failed++; $display("FAIL partial%0d_data_kept: got %h want %h", nb, rx_data, exp_data); end
    endtask

    task automatic test_timeout();
        int v0, f0, e0, k;
        // Counter restarts on the edge the rise takes effect; the strobe registers one edge after it reaches del_to.
        del_to = 20;
        v0 = n_valid; f0 = n_frm; e0 = n_err;
        CSN = 1'b0;
        tick(HALF);
        send_bits($urandom, 3, 1'b0);
        k = last_rise;
        SCLK = 1'b0;
        tick(40);
        tests_run++; if (n_err - e0 != 1) begin tests_failed++; $display("FAIL timeout_err: got %0d want 1", n_err - e0); end
        tests_run++; if (n_frm - f0 != 1) begin tests_failed++; $display("FAIL timeout_frm_end: got %0d want 1", n_frm - f0); end
        tests_run++; if (err_cyc != k + LAT + 21) begin tests_failed++; $display("FAIL timeout_time: got cycle %0d want %0d", err_cyc, k + LAT + 21); end
        tests_run++; if (frm_cyc != err_cyc) begin tests_failed++; $display("FAIL timeout_same_cycle: frm at %0d want %0d", frm_cyc, err_cyc); end
        send_bits($urandom, W, 1'b0);
        end_frame();
        tests_run++; if (n_valid != v0) begin tests_failed++; $display("FAIL timeout_ignored_sclk: got %0d words want 0", n_valid - v0); end
        tests_run++; if (n_err - e0 != 1) begin tests_failed++; $display("FAIL timeout_no_extra_err: got %0d want 1", n_err - e0); end
        v0 = n_valid; e0 = n_err;
        CSN = 1'b0;
        tick(HALF);
        send_bits(32'h5A, W, 1'b0);
        end_frame();
        exp_data = 8'h5A;
        tests_run++; if (n_valid - v0 != 1 || got[v0] !== 8'h5A) begin tests_failed++; $display("FAIL timeout_next_frame: got %0d words first %h want 1 x 5a", n_valid - v0, got[v0]); end
        tests_run++; if (n_err != e0) begin tests_failed++; $display("FAIL timeout_next_err: got %0d want 0", n_err - e0); end
        del_to = '0;
        e0 = n_err;
        CSN = 1'b0;
        tick(HALF);
        send_bits($urandom, 2, 1'b0);
        SCLK = 1'b0;
        tick(100);
        tests_run++; if (n_err != e0) begin tests_failed++; $display("FAIL timeout_disabled: got %0d err want 0", n_err - e0); end
        CSN = 1'b1;
        tick(12);
        tests_run++; if (n_err - e0 != 1) begin tests_failed++; $display("FAIL timeout_disabled_partial: got %0d err want 1", n_err - e0); end
    endtask

    task automatic test_reset_midframe();
        int v0, f0, e0;
        v0 = n_valid; f0 = n_frm; e0 = n_err;
        CSN = 1'b0;
        tick(HALF);
        send_bits($urandom, 4, 1'b0);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        send_bits($urandom, 4 + W, 1'b0);
        SCLK = 1'b0;
        tick(12);
        exp_data = '0;
        tests_run++; if (n_valid != v0) begin tests_failed++; $display("FAIL rstmid_valid: got %0d want 0", n_valid - v0); end
        tests_run++; if (n_frm != f0 || n_err != e0) begin tests_failed++; $display("FAIL rstmid_strobes: frm %0d err %0d want 0 0", n_frm - f0, n_err - e0); end
        tests_run++; if (rx_data !== exp_data) begin tests_failed++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        tests_run++; if (rx_idle !== 1'b1) begin tests_failed++; $display("FAIL rstmid_idle: got %b want 1", rx_idle); end
        CSN = 1'b1;
        tick(12);
        v0 = n_valid;
        CSN = 1'b0;
        tick(HALF);
        send_bits(32'h81, W, 1'b0);
        end_frame();
        exp_data = 8'h81;
        tests_run++; if (n_valid - v0 != 1 || got[v0] !== 8'h81) begin tests_failed++; $display("FAIL rstmid_next_frame: got %0d words first %h want 1 x 81", n_valid - v0, got[v0]); end
    endtask

    task automatic test_random();
        int v0, f0, e0, nw, tail;
        logic [W-1:0] w [3];
        for (int f = 0; f < 6; f++) begin
            nw   = $urandom_range(1, 3);
            tail = $urandom_range(0, W - 1);
            v0 = n_valid; f0 = n_frm; e0 = n_err;
            CSN = 1'b0;
            tick(HALF);
            for (int i = 0; i < nw; i++) begin
                w[i] = W'($urandom);
                send_bits({24'h0, w[i]}, W, 1'b0);
            end
            if (tail != 0) send_bits($urandom, tail, 1'b0);
            end_frame();
            exp_data = w[nw - 1];
            tests_run++; if (n_valid - v0 != nw) begin tests_failed++; $display("FAIL rand%0d_count: got %0d want %0d", f, n_valid - v0, nw); end
            for (int i = 0; i < nw; i++) begin
                tests_run++; if (got[v0 + i] !== w[i]) begin tests_failed++; $display("FAIL rand%0d_data%0d: got %h want %h", f, i, got[v0 + i], w[i]); end
            end
            tests_run++; if (n_err - e0 != ((tail != 0) ? 1 : 0)) begin tests_failed++; $display("FAIL rand%0d_err: got %0d want %0d", f, n_err - e0, (tail != 0) ? 1 : 0); end
            tests_run++; if (n_frm - f0 != 1) begin tests_failed++; $display("FAIL rand%0d_frm_end: got %0d want 1", f, n_frm - f0); end
            tests_run++; if (rx_data !== exp_data) begin tests_failed++; $display("FAIL rand%0d_hold: got %h want %h", f, rx_data, exp_data); end
        end
    endtask

    // Each glitch falls after MOSI is set, so an unfiltered receiver takes every bit twice.
    task automatic test_glitch();
        int v0, e0, k, nexp;
        bit stream [$];
        logic [7:0] v;
        logic [W-1:0] ew [4];
        v = 8'h96;
        for (int i = 7; i >= 0; i--) begin
            stream.push_back(v[i]);
            if (FLAT == 0) stream.push_back(v[i]);
        end
        nexp = stream.size() / W;
        for (int i = 0; i < nexp; i++) begin
            ew[i] = '0;
            for (int b = 0; b < W; b++) ew[i] = {ew[i][W-2:0], stream[i * W + b]};
        end
        v0 = n_valid; e0 = n_err;
        CSN = 1'b0;
        tick(HALF);
        send_bits({24'h0, v}, 8, 1'b1);
        k = last_rise;
        end_frame();
        tests_run++; if (n_valid - v0 != nexp) begin tests_failed++; $display("FAIL glitch_count: got %0d want %0d", n_valid - v0, nexp); end
        for (int i = 0; i < nexp; i++) begin
            tests_run++; if (got[v0 + i] !== ew[i]) begin tests_failed++; $display("FAIL glitch_data%0d: got %h want %h", i, got[v0 + i], ew[i]); end
        end
        tests_run++; if (valid_cyc != k + LAT) begin tests_failed++; $display("FAIL glitch_latency: got cycle %0d want %0d", valid_cyc, k + LAT); end
        tests_run++; if (n_err - e0 != (((stream.size() % W) != 0) ? 1 : 0)) begin tests_failed++; $display("FAIL glitch_err: got %0d", n_err - e0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_partial(5);
        test_partial($urandom_range(1, W - 1));
        test_timeout();
        test_reset_midframe();
        test_random();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
